// File: rtl/ram_sdp_be.sv
// rtl/ram_sdp_be.sv - simple dual-port RAM with byte enables, RDW policy, output pipe and clear sequencer
module ram_sdp_be #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    BYTE_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    OUT_REG        = 0,
    parameter int                    RDW_MODE       = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be,
    input  logic [ADDR_WIDTH-1:0]              write_addr,
    input  logic [DATA_WIDTH-1:0]              data,
    input  logic                               re,
    input  logic [ADDR_WIDTH-1:0]              read_addr,
    output logic [DATA_WIDTH-1:0]              q,
    output logic                               q_valid,
    output logic                               busy
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_clear_wr;
    logic                    w_user_wr;
    logic                    w_rd_en;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;
    logic [DATA_WIDTH-1:0]   w_wr_data;
    logic [NB-1:0]           w_wr_be;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    logic [DATA_WIDTH-1:0]   r_q1;
    logic                    r_v1;

    // Clear sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear sequencer next state: RESET -> CLEAR (or READY) -> READY after the last address
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RESET: w_state_next = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            ST_CLEAR: begin
                if (r_clr_cnt == {ADDR_WIDTH{1'b1}}) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: w_state_next = ST_READY;
            default:  w_state_next = ST_RESET;
        endcase
    end

    // Clear address counter; restarts from 0 on every reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    assign busy = (r_state != ST_READY);

    // Write port arbitration: the clear sequence owns the port while busy, user requests are dropped
    always_comb begin
        w_clear_wr = (r_state == ST_CLEAR) && !rst;
        w_user_wr  = (r_state == ST_READY) && !rst && we;
        w_rd_en    = (r_state == ST_READY) && !rst && re;
        w_wr_addr  = w_clear_wr ? r_clr_cnt : write_addr;
        w_wr_data  = w_clear_wr ? CLEAR_VALUE : data;
        w_wr_be    = w_clear_wr ? {NB{1'b1}} : (w_user_wr ? be : {NB{1'b0}});
    end

    // Byte-lane writes into the array; contents are untouched by rst itself
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (w_wr_be[i]) begin
                r_mem[w_wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Read word selection: old data, or new data merged per lane on a same-address collision
    always_comb begin
        w_rd_word = r_mem[read_addr];
        if ((RDW_MODE != 0) && w_user_wr && (read_addr == write_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    w_rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // First read stage: capture on accepted read, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_rd_en;
            if (w_rd_en) begin
                r_q1 <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_q2;
            logic                  r_v2;

            // Optional output stage: loads only when stage one carries a new read
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q2 <= '0;
                    r_v2 <= 1'b0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_q2 <= r_q1;
                    end
                end
            end

            assign q       = r_q2;
            assign q_valid = r_v2;
        end else begin : g_no_out_reg
            assign q       = r_q1;
            assign q_valid = r_v1;
        end
    endgenerate

endmodule

// File: doc/ram_sdp_be.md
# ram_sdp_be

Parametrised simple dual-port block RAM with one write port and one read port on a single clock. It adds per-byte write enables, a selectable read-during-write policy, an optional output pipeline register with a read-valid strobe, and a hardware clear sequencer that initialises the whole array after reset. It is used as general-purpose on-chip buffer memory in the system memories directory, in places that need byte-granular writes and known contents after reset.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, lane width in bits covered by one byte-enable bit; NB = DATA_WIDTH/BYTE_WIDTH
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
- RDW_MODE, 0, same-address read during write: 0 = old data, 1 = new data, merged per byte
- CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset; 0 = no clear, contents undefined
- CLEAR_VALUE, 0, per-word value written by the clear sequence (DATA_WIDTH bits)
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- we  in  1  write request
- be  in  NB  byte enables; bit i covers data[i*BYTE_WIDTH +: BYTE_WIDTH]
- write_addr  in  ADDR_WIDTH  write address
- data  in  DATA_WIDTH  write data
- re  in  1  read request
- read_addr  in  ADDR_WIDTH  read address
- q  out  DATA_WIDTH  read data
- q_valid  out  1  one-cycle strobe: q holds the data for an accepted read
- busy  out  1  clear sequence in progress; requests are ignored while high

## Operation
- Clear FSM states: RESET, CLEAR, READY. Reset is synchronous, active-high, on the single clock clk.
- While rst is high: state = RESET, clear counter = 0, busy = 1, q = 0, q_valid = 0, output pipeline flushed.
- First cycle with rst low:
  - If CLEAR_ON_RESET = 1: enter CLEAR.
  - If CLEAR_ON_RESET = 0: enter READY.
- CLEAR:
  - Each cycle, write CLEAR_VALUE to the address given by the counter, with all bytes enabled, then increment the counter.
  - After address DEPTH-1 is written, go to READY. The clear takes exactly DEPTH cycles.
  - busy = 1 throughout CLEAR.
- READY: busy = 0. The FSM stays in READY until rst is asserted again.
- Reset asserted mid-clear aborts the clear. The next clear restarts at address 0.
- While busy = 1, we and re are ignored. No user write happens, and q_valid does not pulse.
- Write (READY, we = 1): for each i with be[i] = 1, lane i of ram[write_addr] takes lane i of data. Other lanes are unchanged. we = 1 with be = 0 is a no-op.
- Read (READY, re = 1): ram[read_addr] is captured.
  - re = 0: q holds its previous value.
- Read-during-write (re and we in the same cycle, read_addr == write_addr):
  - RDW_MODE = 0: q returns the pre-write word.
  - RDW_MODE = 1: q returns, lane by lane, data where be is set and the old value elsewhere.
  - Different addresses: the read and the write are independent.
- Array contents are not affected by rst except through the clear sequence.

## Timing
- OUT_REG = 0: a read accepted in cycle N gives q and q_valid = 1 in cycle N+1.
- OUT_REG = 1: a read accepted in cycle N gives q and q_valid = 1 in cycle N+2. The extra stage holds only when it is not loading new data.
- Full throughput: one read and one write per cycle. Back-to-back reads produce back-to-back q_valid pulses.
- Write latency: a write in cycle N is visible to a read accepted in cycle N+1, independent of RDW_MODE.
- busy falls in the cycle after the last clear write. A read accepted in that cycle returns CLEAR_VALUE.
- Reset during a pending read (OUT_REG = 1) flushes that read: q_valid stays 0 and q = 0.

## Test plan
- Reset then clear: CLEAR_ON_RESET = 1, ADDR_WIDTH = 4, CLEAR_VALUE = 0xA5A5A5A5; release rst.
  - busy is high for exactly 16 cycles.
  - Reading all 16 addresses returns 0xA5A5A5A5, with q_valid at N+1 (or N+2 with OUT_REG = 1).
- Byte enables: write 0x11223344 to addr 3 with be = 1111, then 0xAABBCCDD with be = 0101.
  - Reading addr 3 returns 0x11BB33DD.
- Read-during-write: ram[5] = 0x00000000; same cycle we = 1, be = 0011, data = 0xFFFFFFFF, re = 1, read_addr = 5.
  - RDW_MODE = 0: q = 0x00000000.
  - RDW_MODE = 1: q = 0x0000FFFF.
  - Both modes: the next read of addr 5 returns 0x0000FFFF.
- Busy lockout: assert we and re during CLEAR.
  - No q_valid pulse.
  - The target word still equals CLEAR_VALUE afterwards.
- Reset mid-clear: assert rst at counter = 7, release it.
  - busy is high for a full DEPTH cycles again.
  - All words equal CLEAR_VALUE.
- Pipeline: OUT_REG = 1, reads of addr 0..7 on consecutive cycles.
  - Eight consecutive q_valid pulses starting 2 cycles after the first read, with data in order.
  - Asserting rst mid-stream forces q = 0 and q_valid = 0 on the next edge.
